// File: rtl/battle_turn_controller.sv
// Two-fighter round scheduler: accepts both moves, orders strikes by speed, drives the stat blocks.
// Optional dodge roll via an 8-bit LFSR when BATTLE_DODGE_EN is defined.
module battle_turn_controller #(
    parameter int unsigned ATK_DMG    = 10,
    parameter int unsigned HEAVY_DMG  = 20,
    parameter int unsigned HEAVY_COST = 3,
    parameter int unsigned SPEC_DMG   = 35,
    parameter int unsigned SPEC_COST  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_move_valid,
    input  logic [1:0] p1_move,
    output logic       p1_move_ready,
    input  logic       p2_move_valid,
    input  logic [1:0] p2_move,
    output logic       p2_move_ready,
    input  logic [2:0] p1_speed,
    input  logic [2:0] p2_speed,
    input  logic [2:0] p1_dodge,
    input  logic [2:0] p2_dodge,
    input  logic [8:0] p1_health,
    input  logic [8:0] p2_health,
    input  logic [4:0] p1_special,
    input  logic [4:0] p2_special,
    output logic       p1_update,
    output logic       p1_en,
    output logic [5:0] p1_damage,
    output logic [2:0] p1_cost,
    output logic       p2_update,
    output logic       p2_en,
    output logic [5:0] p2_damage,
    output logic [2:0] p2_cost,
    output logic [7:0] round_cnt,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [5:0] AtkDmg    = ATK_DMG[5:0];
    localparam logic [5:0] HeavyDmg  = HEAVY_DMG[5:0];
    localparam logic [2:0] HeavyCost = HEAVY_COST[2:0];
    localparam logic [5:0] SpecDmg   = SPEC_DMG[5:0];
    localparam logic [2:0] SpecCost  = SPEC_COST[2:0];

    typedef enum logic [2:0] {StWait, StOrder, StHit1, StChk1, StHit2, StChk2, StOver} state_e;

    // Packed as {cost[2:0], damage[5:0]}
    function automatic logic [8:0] resolve(input logic [1:0] mv, input logic [4:0] sp);
        logic [8:0] r;
        case (mv)
            2'd0:    r = {3'd0, AtkDmg};
            2'd1:    r = (sp < {2'b0, HeavyCost}) ? {3'd0, AtkDmg} : {HeavyCost, HeavyDmg};
            2'd2:    r = (sp < {2'b0, SpecCost}) ? {3'd0, AtkDmg} : {SpecCost, SpecDmg};
            default: r = '0;
        endcase
        return r;
    endfunction

    state_e     state_q;
    logic       tie_q, first_q;
    logic       p1_lat_q, p2_lat_q;
    logic [1:0] p1_mv_q, p2_mv_q;
    logic [8:0] p1_hold_q, p2_hold_q;

    logic [8:0] p1_res, p2_res, p1_out, p2_out, atk_res;
    logic       pick_p2, atk_p2, def_zero, def_dodge, issue_strike;
    logic       p1_take, p2_take;
    logic [5:0] s_dmg;

`ifdef BATTLE_DODGE_EN
    logic [7:0] lfsr_q;
`else
    logic unused_dodge;
    assign unused_dodge = ^{p1_dodge, p2_dodge};
`endif

    always_comb begin
        p1_res = resolve(p1_mv_q, p1_special);
        p2_res = resolve(p2_mv_q, p2_special);
        if (p1_speed > p2_speed) begin
            pick_p2 = 1'b0;
        end else if (p2_speed > p1_speed) begin
            pick_p2 = 1'b1;
        end else begin
            pick_p2 = tie_q;
        end
        // First strike uses freshly resolved moves; the second reuses what ORDER captured.
        if (state_q == StOrder) begin
            atk_p2 = pick_p2;
            p1_out = p1_res;
            p2_out = p2_res;
        end else begin
            atk_p2 = ~first_q;
            p1_out = p1_hold_q;
            p2_out = p2_hold_q;
        end
        atk_res = atk_p2 ? p2_out : p1_out;
        def_zero = 1'b0;
        if (state_q == StChk1) begin
            def_zero = first_q ? (p1_health == '0) : (p2_health == '0);
        end else if (state_q == StChk2) begin
            def_zero = first_q ? (p2_health == '0) : (p1_health == '0);
        end
        issue_strike = (state_q == StOrder) || ((state_q == StChk1) && !def_zero);
`ifdef BATTLE_DODGE_EN
        def_dodge = lfsr_q[3:0] < {1'b0, (atk_p2 ? p1_dodge : p2_dodge)};
`else
        def_dodge = 1'b0;
`endif
        s_dmg = def_dodge ? '0 : atk_res[5:0];
        p1_take = (state_q == StWait) && p1_move_valid && p1_move_ready;
        p2_take = (state_q == StWait) && p2_move_valid && p2_move_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StWait;
            tie_q         <= 1'b0;
            first_q       <= 1'b0;
            p1_lat_q      <= 1'b0;
            p2_lat_q      <= 1'b0;
            p1_mv_q       <= '0;
            p2_mv_q       <= '0;
            p1_hold_q     <= '0;
            p2_hold_q     <= '0;
            p1_move_ready <= 1'b0;
            p2_move_ready <= 1'b0;
            p1_update     <= 1'b0;
            p1_en         <= 1'b0;
            p1_damage     <= '0;
            p1_cost       <= '0;
            p2_update     <= 1'b0;
            p2_en         <= 1'b0;
            p2_damage     <= '0;
            p2_cost       <= '0;
            round_cnt     <= '0;
            game_over     <= 1'b0;
            winner        <= 2'b00;
`ifdef BATTLE_DODGE_EN
            lfsr_q        <= 8'hA5;
`endif
        end else begin
`ifdef BATTLE_DODGE_EN
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            p1_update <= 1'b0;
            p2_update <= 1'b0;
            p1_en     <= 1'b0;
            p2_en     <= 1'b0;
            unique case (state_q)
                StWait: begin
                    if (p1_take) begin
                        p1_lat_q <= 1'b1;
                        p1_mv_q  <= p1_move;
                    end
                    if (p2_take) begin
                        p2_lat_q <= 1'b1;
                        p2_mv_q  <= p2_move;
                    end
                    p1_move_ready <= !(p1_lat_q || p1_take);
                    p2_move_ready <= !(p2_lat_q || p2_take);
                    if ((p1_lat_q || p1_take) && (p2_lat_q || p2_take)) state_q <= StOrder;
                end
                StOrder: begin
                    if (p1_speed == p2_speed) tie_q <= ~tie_q;
                    first_q   <= pick_p2;
                    p1_hold_q <= p1_res;
                    p2_hold_q <= p2_res;
                    state_q   <= StHit1;
                end
                StHit1: state_q <= StChk1;
                StChk1: begin
                    if (def_zero) begin
                        state_q   <= StOver;
                        game_over <= 1'b1;
                        winner    <= first_q ? 2'b10 : 2'b01;
                        p1_damage <= '0;
                        p1_cost   <= '0;
                        p2_damage <= '0;
                        p2_cost   <= '0;
                    end else begin
                        state_q <= StHit2;
                    end
                end
                StHit2: state_q <= StChk2;
                StChk2: begin
                    p1_damage <= '0;
                    p1_cost   <= '0;
                    p2_damage <= '0;
                    p2_cost   <= '0;
                    if (def_zero) begin
                        state_q   <= StOver;
                        game_over <= 1'b1;
                        winner    <= first_q ? 2'b01 : 2'b10;
                    end else begin
                        state_q       <= StWait;
                        round_cnt     <= round_cnt + 8'd1;
                        p1_lat_q      <= 1'b0;
                        p2_lat_q      <= 1'b0;
                        p1_move_ready <= 1'b1;
                        p2_move_ready <= 1'b1;
                    end
                end
                StOver: ;
                default: state_q <= StWait;
            endcase
            if (issue_strike) begin
                p1_update <= 1'b1;
                p2_update <= 1'b1;
                p1_en     <= atk_p2 && !def_dodge;
                p2_en     <= !atk_p2 && !def_dodge;
                p1_damage <= atk_p2 ? s_dmg : '0;
                p1_cost   <= atk_p2 ? '0 : atk_res[8:6];
                p2_damage <= atk_p2 ? '0 : s_dmg;
                p2_cost   <= atk_p2 ? atk_res[8:6] : '0;
            end
        end
    end

endmodule
